// File: rtl/ex_pkg.sv
// ex_pkg: op codes, control FSM states and forward-select encodings shared by the EX stage
package ex_pkg;
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_NOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLTU = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_LUI  = 4'd11;
   localparam logic [3:0] OP_MUL  = 4'd12;
   localparam logic [3:0] OP_DIVU = 4'd13;
   localparam logic [3:0] OP_REMU = 4'd14;
   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   localparam logic [1:0] FWD_ID  = 2'd0;
   localparam logic [1:0] FWD_WB  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   function automatic logic is_md(input logic [3:0] op);
      return op == OP_MUL || op == OP_DIVU || op == OP_REMU;
   endfunction
endpackage

// File: rtl/mul_div_iter.sv
// mul_div_iter: iterative shift-add multiplier / restoring unsigned divider, one bit per cycle
// Ports: clk, rst (sync, active-low), start/abort control, op/a/b operands,
//        busy while iterating, done on the final iteration, result (low product, quotient or remainder).
module mul_div_iter
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int CW = $clog2(XLEN) + 1;
   // hi: accumulator (mul) or partial remainder (div); lo: multiplier or quotient; m: multiplicand or divisor
   logic [XLEN-1:0] hi, lo, m;
   logic [3:0]      op_q;
   logic [CW-1:0]   count;
   logic [XLEN:0]   rs, diff;
   always_comb begin
      rs   = {hi, lo[XLEN-1]};
      diff = rs - {1'b0, m};
   end
   assign busy   = count != '0;
   assign done   = count == CW'(1);
   assign result = op_q == OP_MUL ? hi : op_q == OP_DIVU ? lo : hi;
   // Divide by zero needs no special case: every trial subtract succeeds,
   // giving an all-ones quotient and the dividend as remainder.
   always_ff @(posedge clk)
      if (!rst) begin
         count <= '0;
         hi    <= '0;
         lo    <= '0;
         m     <= '0;
         op_q  <= OP_ADD;
      end else if (abort) begin
         count <= '0;
      end else if (start) begin
         op_q  <= op;
         count <= CW'(XLEN);
         hi    <= '0;
         lo    <= op == OP_MUL ? b : a;
         m     <= op == OP_MUL ? a : b;
      end else if (busy) begin
         count <= count - CW'(1);
         if (op_q == OP_MUL) begin
            hi <= hi + (lo[0] ? m : '0);
            lo <= lo >> 1;
            m  <= m << 1;
         end else begin
            hi <= diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0];
            lo <= {lo[XLEN-2:0], ~diff[XLEN]};
         end
      end
endmodule

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with MEM/WB forwarding, ALU, iterative mul/div and the EX/MEM register
// Ports: clk, rst (sync, active-low); id_* ID/EX register contents; wb_* WB-stage write port for forwarding;
//        ex_flush squash; stall_out holds the front end; mem_* EX/MEM register outputs.
module ex_stage_mc
   import ex_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_rs_data,
   input  logic [XLEN-1:0] id_rt_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic [RA_W-1:0] id_rd,
   input  logic            id_alu_src,
   input  logic            id_reg_dst,
   input  logic [3:0]      id_alu_op,
   input  logic [1:0]      id_wb,
   input  logic            id_mem_r,
   input  logic            id_mem_w,
   input  logic [XLEN-1:0] wb_data,
   input  logic [RA_W-1:0] wb_reg,
   input  logic            wb_regwrite,
   input  logic            ex_flush,
   output logic            stall_out,
   output logic            mem_valid,
   output logic            mem_read_en,
   output logic            mem_write_en,
   output logic [1:0]      mem_wb,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [RA_W-1:0] mem_dest
);
   localparam int SW = $clog2(XLEN);
   state_t          state;
   logic [1:0]      sel_a, sel_b, md_wb;
   logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu, md_result;
   logic [RA_W-1:0] dest, md_dest;
   logic            md_start, md_busy, md_done, md_r, md_w;
   // MEM beats WB; register 0 is never forwarded
   assign sel_a = (mem_valid && mem_wb[1] && mem_dest != '0 && mem_dest == id_rs) ? FWD_MEM :
                  (wb_regwrite && wb_reg != '0 && wb_reg == id_rs) ? FWD_WB : FWD_ID;
   assign sel_b = (mem_valid && mem_wb[1] && mem_dest != '0 && mem_dest == id_rt) ? FWD_MEM :
                  (wb_regwrite && wb_reg != '0 && wb_reg == id_rt) ? FWD_WB : FWD_ID;
   assign fwd_a = sel_a == FWD_MEM ? mem_addr : sel_a == FWD_WB ? wb_data : id_rs_data;
   assign fwd_b = sel_b == FWD_MEM ? mem_addr : sel_b == FWD_WB ? wb_data : id_rt_data;
   assign op_b  = id_alu_src ? id_imm : fwd_b;
   assign dest  = id_reg_dst ? id_rd : id_rt;
   assign md_start  = state == S_IDLE && id_valid && is_md(id_alu_op) && !ex_flush;
   assign stall_out = rst && (md_start || (state == S_BUSY && !ex_flush));
   always_comb
      case (id_alu_op)
         OP_SUB:  alu = fwd_a - op_b;
         OP_AND:  alu = fwd_a & op_b;
         OP_OR:   alu = fwd_a | op_b;
         OP_XOR:  alu = fwd_a ^ op_b;
         OP_NOR:  alu = ~(fwd_a | op_b);
         OP_SLT:  alu = XLEN'($signed(fwd_a) < $signed(op_b));
         OP_SLTU: alu = XLEN'(fwd_a < op_b);
         OP_SLL:  alu = fwd_a << op_b[SW-1:0];
         OP_SRL:  alu = fwd_a >> op_b[SW-1:0];
         OP_SRA:  alu = $signed(fwd_a) >>> op_b[SW-1:0];
         OP_LUI:  alu = op_b << (XLEN / 2);
         default: alu = fwd_a + op_b;
      endcase
   mul_div_iter #(.XLEN(XLEN)) u_md (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .abort  (ex_flush),
      .op     (id_alu_op),
      .a      (fwd_a),
      .b      (op_b),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );
   always_ff @(posedge clk)
      if (!rst) begin
         state   <= S_IDLE;
         md_dest <= '0;
         md_wb   <= '0;
         md_r    <= 1'b0;
         md_w    <= 1'b0;
      end else if (ex_flush) begin
         state <= S_IDLE;
      end else
         case (state)
            S_IDLE:
               if (md_start) begin
                  state   <= S_BUSY;
                  md_dest <= dest;
                  md_wb   <= id_wb;
                  md_r    <= id_mem_r;
                  md_w    <= id_mem_w;
               end
            S_BUSY:  state <= md_done ? S_DONE : md_busy ? S_BUSY : S_IDLE;
            default: state <= S_IDLE;
         endcase
   // Bubbles clear only the control fields; data fields keep their last value.
   always_ff @(posedge clk)
      if (!rst) begin
         mem_valid    <= 1'b0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         mem_wb       <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_dest     <= '0;
      end else if (!ex_flush && state == S_DONE) begin
         mem_valid    <= 1'b1;
         mem_read_en  <= md_r;
         mem_write_en <= md_w;
         mem_wb       <= md_wb;
         mem_addr     <= md_result;
         mem_dest     <= md_dest;
      end else if (!ex_flush && state == S_IDLE && id_valid && !stall_out) begin
         mem_valid    <= 1'b1;
         mem_read_en  <= id_mem_r;
         mem_write_en <= id_mem_w;
         mem_wb       <= id_wb;
         mem_addr     <= alu;
         mem_wdata    <= fwd_b;
         mem_dest     <= dest;
      end else begin
         mem_valid    <= 1'b0;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
         mem_wb       <= '0;
      end
endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: scoreboard bench for ex_stage_mc with directed vectors
module tb_ex_stage_mc;
   import ex_pkg::*;
   logic        clk = 1'b0, rst = 1'b0;
   logic        id_valid = 0, id_alu_src = 0, id_reg_dst = 0, id_mem_r = 0, id_mem_w = 0;
   logic [31:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0, wb_data = 0;
   logic [4:0]  id_rs = 0, id_rt = 0, id_rd = 0, wb_reg = 0;
   logic [3:0]  id_alu_op = 0;
   logic [1:0]  id_wb = 0;
   logic        wb_regwrite = 0, ex_flush = 0;
   logic        stall_out, mem_valid, mem_read_en, mem_write_en;
   logic [1:0]  mem_wb;
   logic [31:0] mem_addr, mem_wdata;
   logic [4:0]  mem_dest;

   ex_stage_mc #(.XLEN(32), .RA_W(5)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_src(id_alu_src),
      .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op), .id_wb(id_wb), .id_mem_r(id_mem_r),
      .id_mem_w(id_mem_w), .wb_data(wb_data), .wb_reg(wb_reg), .wb_regwrite(wb_regwrite),
      .ex_flush(ex_flush), .stall_out(stall_out), .mem_valid(mem_valid), .mem_read_en(mem_read_en),
      .mem_write_en(mem_write_en), .mem_wb(mem_wb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_dest(mem_dest)
   );

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chkw;
      logic [4:0]  dest;
      logic [1:0]  wb;
      logic        rd;
      logic        wr;
      int          at;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   int compared = 0, mismatched = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } vec_t;
   vec_t vt[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [31:0] addr, input logic [4:0] dest, input logic [1:0] wb,
                       input logic rd, input logic wr, input logic chkw, input logic [31:0] wdata,
                       input int at);
      sb.push_back('{addr, wdata, chkw, dest, wb, rd, wr, at});
   endtask

   task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      id_valid = 1; id_alu_op = op; id_rs_data = a; id_rt_data = b; id_imm = 0;
      id_rs = 1; id_rt = 2; id_rd = 4; id_alu_src = 0; id_reg_dst = 1; id_wb = 2'b10;
      id_mem_r = 0; id_mem_w = 0;
   endtask

   task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r);
      @(posedge clk); #1;
      set_op(op, a, b);
      push(r, 5'd4, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, cyc + 1);
   endtask

   task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r);
      int st;
      st = 0;
      @(posedge clk); #1;
      set_op(op, a, b);
      push(r, 5'd4, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0, cyc + 34);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (stall_out) st++;
         else break;
      end
      chk("stall_cycles", st, 33);
      @(posedge clk); #1;
      id_valid = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, mem_valid, 0);
      chk({tag, "_rd"}, mem_read_en, 0);
      chk({tag, "_wr"}, mem_write_en, 0);
      chk({tag, "_wb"}, mem_wb, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_dest"}, mem_dest, 0);
      chk({tag, "_stall"}, stall_out, 0);
   endtask

   // monitor: every valid EX/MEM entry must match the oldest expectation, at its expected cycle
   always @(negedge clk)
      if (mem_valid === 1'b1) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_valid: got entry addr %0h at cycle %0d, expected none", mem_addr, cyc);
         end else begin
            e = sb.pop_front();
            chk("addr", mem_addr, e.addr);
            chk("dest", mem_dest, e.dest);
            chk("wb", mem_wb, e.wb);
            chk("read_en", mem_read_en, e.rd);
            chk("write_en", mem_write_en, e.wr);
            if (e.chkw) chk("wdata", mem_wdata, e.wdata);
            chk("latency_cycle", cyc, e.at);
         end
      end

   initial begin
      vt = '{
         '{OP_SUB,  32'd5,        32'd7,        32'hFFFF_FFFE},
         '{OP_AND,  32'hF0F0,     32'hFF00,     32'hF000},
         '{OP_OR,   32'hF0F0,     32'h0F0F,     32'hFFFF},
         '{OP_XOR,  32'hFF00,     32'h0FF0,     32'hF0F0},
         '{OP_NOR,  32'h0,        32'hFFFF_0000, 32'h0000_FFFF},
         '{OP_SLT,  32'hFFFF_FFFF, 32'd1,       32'd1},
         '{OP_SLTU, 32'hFFFF_FFFF, 32'd1,       32'd0},
         '{OP_SLTU, 32'd1,        32'hFFFF_FFFF, 32'd1},
         '{OP_SLL,  32'd1,        32'h24,       32'h10},
         '{OP_SRL,  32'h8000_0000, 32'd4,       32'h0800_0000},
         '{OP_SRA,  32'h8000_0000, 32'd4,       32'hF800_0000},
         '{OP_LUI,  32'h1234,     32'hABCD,     32'hABCD_0000},
         '{4'd15,   32'd3,        32'd4,        32'd7}
      };
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst = 1;

      alu(OP_ADD, 32'd5, 32'd7, 32'd12);
      foreach (vt[i]) alu(vt[i].op, vt[i].a, vt[i].b, vt[i].r);

      // double hazard: MEM (0x10) must beat WB (0x20) for r3
      @(posedge clk); #1;
      set_op(OP_ADD, 32'h10, 32'h0); id_rd = 3;
      push(32'h10, 5'd3, 2'b10, 0, 0, 0, 0, cyc + 1);
      @(posedge clk); #1;
      set_op(OP_OR, 32'h99, 32'h0); id_rs = 3; id_rt = 0; id_rd = 0;
      wb_regwrite = 1; wb_reg = 3; wb_data = 32'h20;
      push(32'h10, 5'd0, 2'b10, 0, 0, 0, 0, cyc + 1);
      // r0 is never forwarded even though MEM and WB both target it
      @(posedge clk); #1;
      set_op(OP_OR, 32'h44, 32'h0); id_rs = 0; id_rt = 0; id_rd = 0;
      wb_reg = 0;
      push(32'h44, 5'd0, 2'b10, 0, 0, 0, 0, cyc + 1);

      // store: rt from WB, address base + imm
      @(posedge clk); #1;
      set_op(OP_ADD, 32'h100, 32'h1111); id_rt = 6; id_alu_src = 1; id_imm = 8;
      id_reg_dst = 0; id_wb = 2'b00; id_mem_w = 1;
      wb_reg = 6; wb_data = 32'hABCD;
      push(32'h108, 5'd6, 2'b00, 0, 1, 1, 32'hABCD, cyc + 1);
      // load: MEM holds a store to r6 (no RegWrite), so rs=r6 must not forward
      @(posedge clk); #1;
      set_op(OP_ADD, 32'h200, 32'h0); id_rs = 6; id_rt = 7; id_alu_src = 1; id_imm = 4;
      id_reg_dst = 0; id_wb = 2'b11; id_mem_r = 1;
      wb_regwrite = 0;
      push(32'h204, 5'd7, 2'b11, 1, 0, 0, 0, cyc + 1);
      @(posedge clk); #1;
      id_valid = 0;

      run_md(OP_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
      run_md(OP_DIVU, 32'd100, 32'd7, 32'd14);
      run_md(OP_REMU, 32'd100, 32'd7, 32'd2);
      run_md(OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF);
      run_md(OP_REMU, 32'd9, 32'd0, 32'd9);

      // abort a multiply with ex_flush in cycle 10
      @(posedge clk); #1;
      set_op(OP_MUL, 32'd6, 32'd7);
      repeat (10) @(posedge clk);
      #1;
      chk("stall_before_flush", stall_out, 1);
      ex_flush = 1;
      #1;
      chk("stall_on_flush", stall_out, 0);
      @(posedge clk); #1;
      ex_flush = 0;
      set_op(OP_ADD, 32'd2, 32'd3);
      push(32'd5, 5'd4, 2'b10, 0, 0, 0, 0, cyc + 1);
      #1;
      chk("stall_after_flush", stall_out, 0);
      @(posedge clk); #1;
      id_valid = 0;

      // reset in the middle of a divide discards it
      @(posedge clk); #1;
      set_op(OP_DIVU, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #1;
      rst = 0;
      id_valid = 0;
      @(posedge clk);
      @(negedge clk);
      chk_zero("midreset");
      rst = 1;
      repeat (40) @(posedge clk);
      alu(OP_ADD, 32'd40, 32'd2, 32'd42);
      @(posedge clk); #1;
      id_valid = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised execute stage for the 5-stage pipeline, successor to the fixed 32-bit EX stage. Combines a generic ALU with operand forwarding from MEM and WB, an iterative multiply/divide unit that stalls the front end while busy, and the EX/MEM pipeline register. Sits between the ID/EX register and the data-memory stage. The hazard unit stalls upstream on `stall_out`; the branch unit squashes via `ex_flush`.

## Interface
- `XLEN`, default 32: datapath width, ≥8, power of two.
- `RA_W`, default 5: register-address width.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `id_valid`  in  1  ID/EX holds a live instruction.
- `id_rs_data`, `id_rt_data`, `id_imm`  in  XLEN each  register-file operands and the sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`  in  RA_W each  source and destination register addresses.
- `id_alu_src`  in  1  1 selects `id_imm` as operand B.
- `id_reg_dst`  in  1  1 selects `id_rd` as destination, 0 selects `id_rt`.
- `id_alu_op`  in  4  decoded operation.
- `id_wb`  in  2  bit1 is RegWrite, bit0 is MemToReg.
- `id_mem_r`, `id_mem_w`  in  1 each  load and store.
- `wb_data`  in  XLEN  WB-stage result.
- `wb_reg`  in  RA_W  WB destination register.
- `wb_regwrite`  in  1  WB write enable.
- `ex_flush`  in  1  squash the instruction in EX.
- `stall_out`  out  1  hold IF/ID/ID-EX.
- `mem_valid`, `mem_read_en`, `mem_write_en`  out  1 each  EX/MEM register outputs.
- `mem_wb`  out  2  EX/MEM register output.
- `mem_addr`  out  XLEN  ALU result or memory address.
- `mem_wdata`  out  XLEN  forwarded store data.
- `mem_dest`  out  RA_W  EX/MEM register output.

## Operation
- **Forwarding, operands A and B independently:**
  - MEM hit: `mem_valid & mem_wb[1] & mem_dest!=0 & mem_dest==src`. Forwards `mem_addr`.
  - WB hit: `wb_regwrite & wb_reg!=0 & wb_reg==src`. Forwards `wb_data`.
  - MEM has priority over WB.
  - Register 0 is never forwarded.
  - Load-use hazards belong to the hazard unit, not this block.
- **Operand B:** `id_imm` when `id_alu_src`, otherwise the forwarded rt value. `mem_wdata` always carries the forwarded rt value.
- **Op encoding:**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA: shift A by B[log2(XLEN)-1:0].
  - 11 LUI: B << XLEN/2.
  - 12 MUL: low XLEN bits of the product.
  - 13 DIVU, 14 REMU: unsigned.
  - 15 is reserved and executes as ADD.
- **Arithmetic:** all results are truncated to XLEN. There is no overflow trap. Divide by zero returns quotient all-ones and remainder equal to the dividend.
- **Mul/div FSM:**
  - `IDLE -> BUSY` when `id_valid` and op is in 12..14. Forwarded operands, op, dest and control are latched and the count is loaded with XLEN.
  - `BUSY`: one shift-add or restore-subtract iteration per cycle. Moves to `DONE` at count 0.
  - `DONE -> IDLE` unconditionally. `DONE` never starts a new operation.
- **`stall_out`:** `(IDLE & id_valid & op in 12..14 & !ex_flush) | BUSY`.
- **EX/MEM register:**
  - Captures a single-cycle op when `id_valid & !stall_out & state==IDLE`.
  - Captures the latched mul/div result in `DONE`.
  - Otherwise loads a bubble: `mem_valid`, `mem_wb`, `mem_read_en` and `mem_write_en` are 0; data fields hold their previous values.
- **`ex_flush`:** the EX/MEM register loads a bubble that cycle. From any state the FSM returns to IDLE, aborting any divide. `stall_out` drops in the same cycle.

## Timing
- **Reset:** while `rst`=0 at an edge, all outputs are 0, the FSM is IDLE, the count is 0 and `stall_out` is 0. Reset mid-operation discards it with no partial write.
- **Single-cycle ops:** latency 1. Result is visible on `mem_*` the cycle after presentation.
- **Mul/div:**
  - `stall_out` is high for XLEN+1 consecutive cycles.
  - The result appears on `mem_*` XLEN+2 cycles after first presentation.
  - Exactly one valid EX/MEM entry is produced per instruction.
- **Forwarding mux:** combinational, same cycle, no extra latency.
- **Flush and DONE in the same cycle:** flush wins and the result is dropped.

## Structure
- **Package `ex_pkg`:** op-code localparams (`OP_ADD`..`OP_REMU`), FSM state encodings (`S_IDLE`, `S_BUSY`, `S_DONE`) and forward-select encodings.
- **Sub-module `mul_div_iter`:** XLEN-parametrised shift-add/restoring engine.
  - Inputs: start, op, a, b.
  - Outputs: busy, done, result.
- The top level holds the forwarding, ALU, control FSM and EX/MEM register.

## Test plan
- **Reset then ADD:** A=5, B=7 with no hazards. Next cycle `mem_addr`=12, `mem_valid`=1.
- **Double hazard:** prior instruction writes r3 (MEM has 0x10) and WB writes r3=0x20; current `rs`=r3, op OR, B=0. `mem_addr`=0x10, showing MEM priority. A repeat with rs=r0 and both stages targeting r0 gives A=`id_rs_data`.
- **MUL (XLEN=32):** 0xFFFF_FFFF × 3. `stall_out` is high for 33 cycles. `mem_addr`=0xFFFF_FFFD exactly 34 cycles after presentation, with exactly one `mem_valid` pulse.
- **DIVU and REMU:** 100/7 gives 14; REMU gives 2. DIVU by 0 gives 0xFFFF_FFFF; REMU 9 by 0 gives 9.
- **Abort:** `ex_flush` during BUSY, cycle 10. `stall_out` drops the same cycle, no `mem_valid`, and the next ADD completes in 1 cycle. Asserting `rst`=0 mid-BUSY instead gives all-zero outputs.
- **Store forwarding:** store with rt forwarded from WB=0xABCD and B=imm 8. `mem_write_en`=1, `mem_wdata`=0xABCD, `mem_addr`=base+8.
